pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
Parametrised, pipelined integer adder/subtractor replacing the fixed 32-bit combinational adder in the MIPS datapath.
- Carry chain split into STAGES equal slices, one slice per pipeline stage, so wide adds close timing on the xc6slx9.
- Produces sum/difference, carry-out, signed overflow and zero flag.
- valid/ready handshake with full back-pressure; sits between the ID/EX operand registers and the ALU result mux.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
STAGES, 2, pipeline depth and number of carry-chain slices (1..WIDTH); latency equals STAGES cycles.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat present
in_ready  out  1  block can accept a beat this cycle
op_sub  in  1  0 = A+B, 1 = A-B (A + ~B + 1)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result beat present
out_ready  in  1  consumer accepts result
result  out  WIDTH  sum/difference
carry_out  out  1  unsigned carry (add) / no-borrow (sub)
overflow  out  1  signed two's-complement overflow
zero  out  1  result == 0

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits, result, carry_out, overflow and zero clear to 0 immediately. in_ready is 1 after reset.
- Slice width S = WIDTH/STAGES.
  - Stage k (0-based) adds bits [k*S +: S] of A and B (B inverted when sub) plus the carry registered by stage k-1.
  - Stage 0 uses op_sub as carry-in.
  - Unconsumed upper operand slices and op_sub travel forward in skew registers.
  - Completed lower result slices travel forward in de-skew registers.
- Handshake:
  - advance = !out_valid || out_ready.
  - All stages shift together on advance.
  - in_ready = advance (combinational from out_valid/out_ready only; never from in_valid).
  - A beat is accepted when in_valid && in_ready.
  - Bubbles propagate as valid=0 stages; they are not collapsed.
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+STAGES if no stall. Throughput is 1 beat/cycle.
- Stall: when out_valid && !out_ready, every stage register including the outputs holds its value. in_ready=0.
- Flags, computed in the last stage from the full result:
  - carry_out = carry from the MSB slice.
  - overflow = (sign_a == sign_b_eff) && (sign_r != sign_a), where sign_b_eff = b[MSB] ^ op_sub.
  - zero = ~|result.
- Wrap-around: results are modulo 2^WIDTH. Overflow is flagged but does not alter the result (unless SATURATE_EN).
- Output data is stable while out_valid && !out_ready.
- When out_valid=0, data outputs hold their last value; consumers must ignore them.
- STAGES=1: a single registered adder; latency 1, same handshake.
- Reset mid-operation: all in-flight beats are discarded and no partial result is emitted.
- Simultaneous out_ready and in_valid while full: the output is consumed and the new beat is accepted in the same cycle.
- Elaboration: WIDTH % STAGES != 0 or STAGES < 1 triggers $error at elaboration.

Optional Feature:
ADDSUB_SATURATE_EN
- Defined: an extra saturate control bit travels with each beat (input port sat, 1 bit).
  - If sat=1 and overflow=1, result clamps to the most positive value (A non-negative) or the most negative value (A negative).
  - overflow still reports 1; zero and carry_out are computed from the unclamped sum.
  - The clamp is done in the last stage with no added latency.
- Not defined: the sat port is absent and results always wrap.

Decomposition:
- Package addsub_pkg:
  - OP_ADD=1'b0, OP_SUB=1'b1 constants.
  - A flags struct typedef {carry, overflow, zero}.
  - Function slice_width(WIDTH, STAGES).
- One natural sub-module: addsub_slice (parameter S). Combinational S-bit add with carry in/out, instantiated STAGES times via generate.
- Pipeline registers, skew/de-skew and handshake live in the top module.

Test Plan:
1. WIDTH=32, STAGES=2; add 0x0000_0001 + 0x0000_0001 -> result 0x0000_0002, carry 0, overflow 0, zero 0, out_valid exactly 2 cycles after acceptance.
2. Add 0xFFFF_FFFF + 0x0000_0001 -> result 0, carry_out 1, zero 1, overflow 0; carry crosses the slice boundary at bit 16.
3. Sub 0x8000_0000 - 0x0000_0001 -> result 0x7FFF_FFFF, overflow 1. With ADDSUB_SATURATE_EN and sat=1 -> result 0x8000_0000, overflow 1.
4. Stream 8 back-to-back beats with out_ready held 0 for cycles 3-5 -> in_ready=0 during the stall, no beat lost or duplicated, and outputs appear in order matching the reference model.
5. Assert rst_n low asynchronously while 2 beats are in flight -> out_valid drops the same cycle, no stale result after release, in_ready=1 on the first clock after release.
6. Sweep STAGES in {1,4,32} with WIDTH=32, 1000 random operand/op pairs each -> bit-exact versus the reference model, with latency equal to STAGES.

Source files
------------

// File: rtl/addsub_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | addsub_pkg : shared constants, flag struct and slicing helper for        |
// |              pipelined_addsub.                           Rev 1.0         |
// +--------------------------------------------------------------------------+
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;

  // Guarded so a bad STAGES reaches the elaboration check instead of a divide by zero.
  function automatic int slice_width(input int width, input int stages);
    return (stages < 1) ? width : width / stages;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | addsub_slice : S-bit combinational adder with carry in/out; one per      |
// |                pipeline stage of pipelined_addsub.       Rev 1.0         |
// +--------------------------------------------------------------------------+
module addsub_slice #(
  parameter int S = 16
) (
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic         cin,
  output logic [S-1:0] sum,
  output logic         cout
);

  logic [S:0] total;

  assign total       = {1'b0, a} + {1'b0, b} + {{S{1'b0}}, cin};
  assign {cout, sum} = total;

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipelined_addsub : carry chain cut into STAGES slices, valid/ready with  |
// | full back-pressure. Option macro ADDSUB_SATURATE_EN adds per-beat `sat`. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
`ifdef ADDSUB_SATURATE_EN
  input  logic             sat,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int S    = slice_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;
  localparam int MSB  = WIDTH - 1;

  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  if ((STAGES < 1) || ((WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0)) begin : g_param_check
    $error("pipelined_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d >= 1)", WIDTH, STAGES);
  end

  // Stage registers; index k holds the state produced by stage k.
  logic             valid_q  [STAGES];
  logic [WIDTH-1:0] a_sk     [STAGES];
  logic [WIDTH-1:0] b_sk     [STAGES];
  logic             op_sk    [STAGES];
  logic             sa_sk    [STAGES];
  logic             sb_sk    [STAGES];
  logic             carry_sk [STAGES];
  logic [WIDTH-1:0] res_sk   [STAGES];
  flags_t           flags_q;
`ifdef ADDSUB_SATURATE_EN
  logic             sat_sk   [STAGES];
  logic             src_sat  [STAGES];
`endif

  // Inputs seen by each stage this cycle.
  logic             src_valid [STAGES];
  logic [WIDTH-1:0] src_a     [STAGES];
  logic [WIDTH-1:0] src_b     [STAGES];
  logic             src_op    [STAGES];
  logic             src_sa    [STAGES];
  logic             src_sb    [STAGES];
  logic             src_carry [STAGES];
  logic [WIDTH-1:0] src_res   [STAGES];

  logic [WIDTH-1:0] nxt_res   [STAGES];
  logic             nxt_carry [STAGES];
  flags_t           nxt_flags;
  logic [WIDTH-1:0] final_res;
  logic             advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [S-1:0]     b_slice;
    logic [S-1:0]     slice_sum;
    logic [WIDTH-1:0] res_merge;

    if (k == 0) begin : g_head
      assign src_valid[k] = in_valid;
      assign src_a[k]     = a;
      assign src_b[k]     = b;
      assign src_op[k]    = op_sub;
      assign src_sa[k]    = a[MSB];
      assign src_sb[k]    = b[MSB];
      assign src_carry[k] = op_sub;
      assign src_res[k]   = '0;
`ifdef ADDSUB_SATURATE_EN
      assign src_sat[k]   = sat;
`endif
    end else begin : g_body
      assign src_valid[k] = valid_q[k-1];
      assign src_a[k]     = a_sk[k-1];
      assign src_b[k]     = b_sk[k-1];
      assign src_op[k]    = op_sk[k-1];
      assign src_sa[k]    = sa_sk[k-1];
      assign src_sb[k]    = sb_sk[k-1];
      assign src_carry[k] = carry_sk[k-1];
      assign src_res[k]   = res_sk[k-1];
`ifdef ADDSUB_SATURATE_EN
      assign src_sat[k]   = sat_sk[k-1];
`endif
    end

    // Operand skew registers are pre-shifted, so every stage works on the low S bits.
    assign b_slice = (src_op[k] == OP_SUB) ? ~src_b[k][S-1:0] : src_b[k][S-1:0];

    addsub_slice #(
      .S (S)
    ) u_slice (
      .a    (src_a[k][S-1:0]),
      .b    (b_slice),
      .cin  (src_carry[k]),
      .sum  (slice_sum),
      .cout (nxt_carry[k])
    );

    always_comb begin
      res_merge            = src_res[k];
      res_merge[k*S +: S]  = slice_sum;
    end

    assign nxt_res[k] = res_merge;
  end

  // Flags come from the full, unclamped sum of the final stage.
  logic sign_b_eff;
  logic ovf;
  logic sat_hit;

  assign sign_b_eff         = src_sb[LAST] ^ src_op[LAST];
  assign ovf                = (src_sa[LAST] == sign_b_eff) && (nxt_res[LAST][MSB] != src_sa[LAST]);
  assign nxt_flags.carry    = nxt_carry[LAST];
  assign nxt_flags.overflow = ovf;
  assign nxt_flags.zero     = ~|nxt_res[LAST];

`ifdef ADDSUB_SATURATE_EN
  assign sat_hit = src_sat[LAST] & ovf;
`else
  assign sat_hit = 1'b0;
`endif

  assign final_res = sat_hit ? (src_sa[LAST] ? MOST_NEG : MOST_POS) : nxt_res[LAST];

  assign out_valid = valid_q[LAST];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign result    = res_sk[LAST];
  assign carry_out = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;

  // Data registers load only behind a valid beat, so idle outputs keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k]  <= 1'b0;
        a_sk[k]     <= '0;
        b_sk[k]     <= '0;
        op_sk[k]    <= 1'b0;
        sa_sk[k]    <= 1'b0;
        sb_sk[k]    <= 1'b0;
        carry_sk[k] <= 1'b0;
        res_sk[k]   <= '0;
`ifdef ADDSUB_SATURATE_EN
        sat_sk[k]   <= 1'b0;
`endif
      end
      flags_q <= '0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= src_valid[k];
        if (src_valid[k]) begin
          a_sk[k]     <= src_a[k] >> S;
          b_sk[k]     <= src_b[k] >> S;
          op_sk[k]    <= src_op[k];
          sa_sk[k]    <= src_sa[k];
          sb_sk[k]    <= src_sb[k];
          carry_sk[k] <= nxt_carry[k];
          res_sk[k]   <= (k == LAST) ? final_res : nxt_res[k];
`ifdef ADDSUB_SATURATE_EN
          sat_sk[k]   <= src_sat[k];
`endif
        end
      end
      if (src_valid[LAST]) begin
        flags_q <= nxt_flags;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipelined_addsub : four DUTs (STAGES 2,1,4,32) share one stimulus     |
// | stream; per-DUT scoreboards check data, flags, latency. Rev 1.0          |
// +--------------------------------------------------------------------------+
module tb_pipelined_addsub;
  import addsub_pkg::*;

  localparam int NDUT = 4;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    int          cyc;
    int          stalls;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        op_in;
  logic        sat_in;
  logic [31:0] a_in;
  logic [31:0] b_in;

  logic [NDUT-1:0] in_ready_w;
  logic [NDUT-1:0] out_valid_w;
  logic [NDUT-1:0] carry_w;
  logic [NDUT-1:0] ovf_w;
  logic [NDUT-1:0] zero_w;
  logic [31:0]     result_w [NDUT];

  int checks = 0;
  int errors = 0;
  int pend [NDUT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: true signed result in 64-bit arithmetic, then wrapped / clamped.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic op, input logic s);
    exp_t            m;
    longint          sa, sb, t;
    longint unsigned ua, ub;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    t  = (op == OP_SUB) ? sa - sb : sa + sb;
    m     = '0;
    m.o   = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    m.res = t[31:0];
    m.c   = (op == OP_SUB) ? (ua >= ub) : ((ua + ub) > 64'd4294967295);
    m.z   = (m.res == 32'd0);
    if (s && m.o) m.res = av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return m;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    localparam int ST = (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 4 : 32;

    exp_t        q[$];
    exp_t        e_new;
    exp_t        e_head;
    int          cyc = 0;
    int          stalls = 0;
    bit          prev_hold = 1'b0;
    logic [34:0] prev_out;
    logic        sat_eff;

`ifdef ADDSUB_SATURATE_EN
    assign sat_eff = sat_in;
`else
    assign sat_eff = 1'b0;
`endif

    pipelined_addsub #(
      .WIDTH  (32),
      .STAGES (ST)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[i]),
      .op_sub    (op_in),
`ifdef ADDSUB_SATURATE_EN
      .sat       (sat_in),
`endif
      .a         (a_in),
      .b         (b_in),
      .out_valid (out_valid_w[i]),
      .out_ready (out_ready),
      .result    (result_w[i]),
      .carry_out (carry_w[i]),
      .overflow  (ovf_w[i]),
      .zero      (zero_w[i])
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        prev_hold = 1'b0;
        pend[i]   = 0;
      end else begin
        checks++;
        if (in_ready_w[i] !== (!out_valid_w[i] || out_ready)) begin
          errors++;
          $display("FAIL handshake dut%0d ST=%0d in_ready=%b need %b", i, ST,
                   in_ready_w[i], !out_valid_w[i] || out_ready);
        end
        if (out_valid_w[i] === 1'b1) begin
          if (prev_hold) begin
            checks++;
            if ({result_w[i], carry_w[i], ovf_w[i], zero_w[i]} !== prev_out) begin
              errors++;
              $display("FAIL hold_stable dut%0d ST=%0d got %h need %h", i, ST,
                       {result_w[i], carry_w[i], ovf_w[i], zero_w[i]}, prev_out);
            end
          end else if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output dut%0d ST=%0d result=%h", i, ST, result_w[i]);
          end else begin
            e_head = q[0];
            checks++;
            if (result_w[i] !== e_head.res || carry_w[i] !== e_head.c ||
                ovf_w[i] !== e_head.o || zero_w[i] !== e_head.z) begin
              errors++;
              $display("FAIL data dut%0d ST=%0d got res=%h c=%b o=%b z=%b need res=%h c=%b o=%b z=%b",
                       i, ST, result_w[i], carry_w[i], ovf_w[i], zero_w[i],
                       e_head.res, e_head.c, e_head.o, e_head.z);
            end
            checks++;
            if (cyc - e_head.cyc != ST + stalls - e_head.stalls) begin
              errors++;
              $display("FAIL latency dut%0d ST=%0d got %0d need %0d", i, ST,
                       cyc - e_head.cyc, ST + stalls - e_head.stalls);
            end
          end
          if (out_ready && q.size() > 0) q.delete(0);
        end
        if (in_valid && in_ready_w[i]) begin
          e_new        = model(a_in, b_in, op_in, sat_eff);
          e_new.cyc    = cyc;
          e_new.stalls = stalls;
          q.push_back(e_new);
        end
        if (out_valid_w[i] && !out_ready) stalls++;
        prev_hold = out_valid_w[i] && !out_ready;
        prev_out  = {result_w[i], carry_w[i], ovf_w[i], zero_w[i]};
        pend[i]   = q.size();
        cyc++;
      end
    end
  end

  task automatic check1(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s dut%0d got %h need %h", name, idx, got, need);
    end
  endtask

  // Offers one beat and holds it until the STAGES=2 DUT takes it; returns at posedge+1.
  task automatic send_beat(input logic [31:0] av, input logic [31:0] bv,
                           input logic op, input logic s);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    a_in     = av;
    b_in     = bv;
    op_in    = op;
    sat_in   = s;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (in_ready_w[0]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=0 need 1 within 64 cycles");
    end
  endtask

  task automatic drain();
    bit done;
    done      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(posedge clk);
      done = (out_valid_w == '0);
      for (int i = 0; i < NDUT; i++) if (pend[i] != 0) done = 1'b0;
    end
    #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain got pending beats need none after 200 cycles");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish need finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_in     = OP_ADD;
    sat_in    = 1'b0;
    a_in      = '0;
    b_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check1("reset_out_valid", i, {31'd0, out_valid_w[i]}, 32'd0);
      check1("reset_in_ready", i, {31'd0, in_ready_w[i]}, 32'd1);
      check1("reset_result", i, result_w[i], 32'd0);
      check1("reset_flags", i, {29'd0, carry_w[i], ovf_w[i], zero_w[i]}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corners.
    send_beat(32'h0000_0001, 32'h0000_0001, OP_ADD, 1'b0);
    send_beat(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0);
    send_beat(32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0);
    send_beat(32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b1);
    send_beat(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b1);
    send_beat(32'h1234_5678, 32'h1234_5678, OP_SUB, 1'b0);
    send_beat(32'h0000_0000, 32'h0000_0001, OP_SUB, 1'b0);
    drain();

    // Back-to-back stream with a three-cycle consumer stall.
    fork
      begin
        for (int n = 0; n < 8; n++) send_beat($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with beats in flight.
    send_beat(32'h0000_0005, 32'h0000_0007, OP_ADD, 1'b0);
    send_beat(32'h0000_0009, 32'h0000_0003, OP_SUB, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check1("async_reset_out_valid", i, {31'd0, out_valid_w[i]}, 32'd0);
      check1("async_reset_result", i, result_w[i], 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) check1("release_in_ready", i, {31'd0, in_ready_w[i]}, 32'd1);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NDUT; i++) check1("no_stale_output", i, {31'd0, out_valid_w[i]}, 32'd0);
      @(posedge clk);
      #1;
    end

    // Randomised traffic with random back-pressure.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      a_in      = rnd_operand();
      b_in      = rnd_operand();
      op_in     = 1'($urandom_range(0, 1));
      sat_in    = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
